// File: rtl/neuron_rate_decoder_pkg.sv
// Shared constants, FSM state, result record and hysteresis rule for the
// neuron rate decoder.
package neuron_pkg;

    localparam int WINDOW_DEF    = 16;
    localparam int HI_THRESH_DEF = 10;
    localparam int LO_THRESH_DEF = 6;
    localparam int CNT_W_DEF     = $clog2(WINDOW_DEF + 1);
    // Wide enough for any legal WINDOW (up to 255).
    localparam int MAX_CNT_W     = 8;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] count;
        logic                 active;
    } result_t;

    // Set at or above hi, clear at or below lo, otherwise hold.
    function automatic logic next_active(input logic [MAX_CNT_W-1:0] count,
                                         input logic prev, input int hi, input int lo);
        if (int'(count) >= hi) return 1'b1;
        if (int'(count) <= lo) return 1'b0;
        return prev;
    endfunction

endpackage

// File: rtl/neuron_rate_decoder_if.sv
// Valid/ready result port from the rate decoder to the readout logic.
interface neuron_rate_decoder_if #(
    parameter int CNT_W = neuron_pkg::CNT_W_DEF
);
    import neuron_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_active;

    modport master (output out_valid, out_count, out_active, input out_ready);
    modport slave  (input out_valid, out_count, out_active, output out_ready);

endinterface

// File: rtl/spike_edge_detect.sv
// Registers the incoming spike and produces the per-cycle event term:
// the level itself, or only its rising edge when EDGE_MODE is set.
module spike_edge_detect #(
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic spike,
    output logic spike_evt
);

    logic spike_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
        end else if (clr) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike;
        end
    end

    assign spike_evt = spike & ~(EDGE_MODE & spike_q);

endmodule

// File: rtl/neuron_rate_decoder.sv
// Counts neuron firing over fixed windows, classifies each window with
// hysteresis and offers the result on a valid/ready port.
module neuron_rate_decoder
    import neuron_pkg::*;
#(
    parameter int WINDOW    = WINDOW_DEF,
    parameter int HI_THRESH = HI_THRESH_DEF,
    parameter int LO_THRESH = LO_THRESH_DEF,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   spike,
    neuron_rate_decoder_if.master  rd,
    output logic                   overrun
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int WIN_W = $clog2(WINDOW);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] evt_q, evt_d, evt_sum;
    logic             spike_evt;
    logic             load;
    result_t          res_q, res_d;
    logic             valid_q;
    logic             overrun_q;

    spike_edge_detect #(.EDGE_MODE(EDGE_MODE)) u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .spike     (spike),
        .spike_evt (spike_evt)
    );

    assign evt_sum = evt_q + CNT_W'(spike_evt);

    // NOTE: every variable written here gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        evt_d   = evt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The enabling clock is already sample 0 of the window.
                if (en) begin
                    state_d = RUN;
                    win_d   = WIN_W'(1);
                    evt_d   = evt_sum;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    win_d   = '0;
                    evt_d   = '0;
                end else if (win_q == WIN_W'(WINDOW - 1)) begin
                    load  = 1'b1;
                    win_d = '0;
                    evt_d = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                    evt_d = evt_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_d        = '0;
        res_d.count  = MAX_CNT_W'(evt_sum);
        res_d.active = next_active(res_d.count, res_q.active, HI_THRESH, LO_THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            evt_q     <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clr) begin
            state_q   <= IDLE;
            win_q     <= '0;
            evt_q     <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            evt_q   <= evt_d;
            if (load) begin
                res_q   <= res_d;
                valid_q <= 1'b1;
                // Overwriting a result nobody took is the only overrun case.
                if (valid_q && !rd.out_ready) overrun_q <= 1'b1;
            end else if (valid_q && rd.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // A window can never hold more events than it has samples.
    assert property (@(posedge clk) disable iff (!rst_n) res_q.count <= MAX_CNT_W'(WINDOW));

    assign rd.out_valid  = valid_q;
    assign rd.out_count  = res_q.count[CNT_W-1:0];
    assign rd.out_active = res_q.active;
    assign overrun       = overrun_q;

endmodule

// File: doc/neuron_rate_decoder.md
Name: neuron_rate_decoder

Overview:
- Downstream stage of the threshold-neuron network; consumes the 1-bit output of the final-layer neuron, sampled every clock.
- Counts firing over fixed windows of WINDOW cycles and applies hysteresis to decide a stable "active" class.
- Presents each window result on a valid/ready port to the pin-mapping/readout logic.

Parameters:
- WINDOW, 16, window length in sampled cycles; legal range 2..255.
- HI_THRESH, 10, count at or above which out_active sets; must satisfy LO_THRESH < HI_THRESH <= WINDOW.
- LO_THRESH, 6, count at or below which out_active clears.
- EDGE_MODE, 0, 0 counts cycles where spike is high; 1 counts rising edges of spike only.
- CNT_W, $clog2(WINDOW+1), derived width of the count fields; not overridden.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, sampling enable; windows advance only while high.
- clr, input, 1, synchronous clear; highest priority after reset.
- spike, input, 1, neuron output, already registered upstream.
- out_ready, input, 1, consumer accepts the result when high together with out_valid.
- out_valid, output, 1, a window result is held on the result outputs.
- out_count, output, CNT_W, number of counted events in the completed window.
- out_active, output, 1, hysteresis class bit for the completed window.
- overrun, output, 1, sticky flag: an unaccepted result was overwritten.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_count=0, out_active=0, overrun=0; internal window counter=0, event counter=0, spike_q=0; FSM=IDLE.
- FSM IDLE: entered on reset, clr, or en low. Moves to RUN on the first clock with en=1. That clock is window sample 0.
- FSM RUN: each clock samples one cycle. The event counter adds the event term. In level mode the event term is spike. In edge mode it is spike & ~spike_q.
- spike_q registers spike every clock regardless of en. It is cleared only by reset or clr.
- Window close: on the clock where the window counter equals WINDOW-1, the result is loaded on that same edge. The event counter and window counter return to 0. The next window starts on the following clock with no gap cycle. Latency from the last sample to out_valid=1 is 1 clock.
- Result load: out_count = event count including the final sample; the event count never exceeds WINDOW, so no saturation logic is needed.
- Hysteresis: out_active sets if the count is >= HI_THRESH. It clears if the count is <= LO_THRESH. Otherwise it keeps its previous value. out_active updates only on result load.
- Handshake: out_valid stays 1 and out_count/out_active stay stable until a clock with out_valid & out_ready. On that clock out_valid drops to 0 unless a new result loads on the same edge.
- Simultaneous accept and load: the new result is loaded, out_valid stays 1, and overrun does not change.
- Load while out_valid=1 and out_ready=0: the new result overwrites the old one and overrun sets to 1. overrun is cleared only by reset or clr.
- en low mid-window: the partial window is discarded and the counters are cleared. FSM goes to IDLE. A pending result and overrun are kept, and the handshake still completes.
- clr: on the clock edge it clears everything cleared by reset, including out_valid and any pending result. It overrides a window close and an accept on the same edge.

Decomposition:
- The shared package neuron_pkg holds:
  - the default window, threshold and counter-width constants;
  - the FSM state enum typedef (IDLE, RUN);
  - a result struct typedef (count, active).
- One sub-module, spike_edge_detect: registered spike_q, clr input, and an output that selects the level or rising-edge event term according to EDGE_MODE.
- The window and event counters, FSM, hysteresis and handshake register stay in the top module.

Test Plan:
- Level mode, out_ready=1, spike high for 12 of 16 cycles -> one clock after sample 15: out_valid=1, out_count=12, out_active=1; out_valid drops to 0 on the next clock.
- Hysteresis, three windows with counts 12, 8, 5 -> out_active 1, 1 (held), 0; out_count 12, 8, 5.
- Edge mode, spike toggles every cycle for 16 cycles starting low -> out_count=8. Then spike held high for 16 cycles -> out_count=1 if it rose in-window, 0 if it was already high.
- Backpressure, out_ready=0 across two window closes with counts 3 then 9 -> out_count=9, overrun=1. Then out_ready=1 -> accepted. overrun stays 1 until clr pulses.
- en dropped at sample 7 after 5 spikes, re-raised with 16 quiet cycles -> a single result with out_count=0; the partial count is not carried over.
- rst_n pulsed low asynchronously mid-window with out_valid=1 -> all outputs read 0 immediately, and the next result arrives exactly 16 clocks after en resumes.
